axis_stall_watchdog: RTL and testbench

Parametrised next-generation deadlock/stall monitor for HLS dataflow regions in the filter/phase chain. It watches N_AXIS AXI-Stream blocked flags plus N_INST sub-instance block/idle pairs. A stall is flagged only after a block persists for a programmable number of cycles. On a flag it reports which channels are stalled, which tripped first, how long the stall has lasted and how many stall events have occurred. An optional sticky mode holds the report until software clears it.

---
 rtl/axis_stall_watchdog.sv | 141 ++++++++++++++
 tb/tb_axis_stall_watchdog.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_stall_watchdog.sv
// Stall/deadlock monitor for HLS dataflow regions: flags AXIS channels or sub-instances
// that stay blocked, and reports the stalled set, first source, duration and event count.
module axis_stall_watchdog #(
  parameter int unsigned N_AXIS = 2,
  parameter int unsigned N_INST = 1,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned STICKY = 0,
  parameter int unsigned IDX_W  = ((N_AXIS + N_INST) > 1) ? $clog2(N_AXIS + N_INST) : 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [CNT_W-1:0]                       threshold,
  input  logic                                   clear,
  input  logic [N_AXIS-1:0]                      axis_block_sigs,
  input  logic [((N_INST > 0) ? N_INST : 1)-1:0] inst_idle_sigs,
  input  logic [((N_INST > 0) ? N_INST : 1)-1:0] inst_block_sigs,
  output logic [2*N_AXIS-1:0]                    axis_block_info,
  output logic                                   block,
  output logic [IDX_W-1:0]                       first_idx,
  output logic [CNT_W-1:0]                       stall_cycles,
  output logic [7:0]                             trip_count
);

  localparam int unsigned NSRC = N_AXIS + N_INST;

  typedef enum logic [1:0] {
    S_MONITOR = 2'd0,
    S_BLOCKED = 2'd1,
    S_LATCHED = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt [N_AXIS];
  logic [2*N_AXIS-1:0] r_info;
  logic                r_block;
  logic [IDX_W-1:0]    r_first;
  logic [CNT_W-1:0]    r_stall;
  logic [7:0]          r_trips;

  logic [CNT_W:0]      w_thr_e;
  logic [NSRC-1:0]     w_trip;
  logic [2*N_AXIS-1:0] w_code;
  logic                w_any;
  logic [IDX_W-1:0]    w_first;

  // Trip detection; compare is one bit wider so a saturated counter still trips.
  always_comb begin
    w_thr_e = (threshold == '0) ? (CNT_W+1)'(1) : {1'b0, threshold};
    w_trip  = '0;
    w_code  = '0;
    for (int i = 0; i < int'(N_AXIS); i++) begin
      w_trip[i] = axis_block_sigs[i] &&
                  (({1'b0, r_cnt[i]} + (CNT_W+1)'(1)) >= w_thr_e);
      if (w_trip[i]) begin
        w_code[2*i +: 2] = ((i % 2) == 0) ? 2'b10 : 2'b01;
      end
    end
    for (int j = 0; j < int'(N_INST); j++) begin
      w_trip[N_AXIS + j] = inst_block_sigs[j] & ~inst_idle_sigs[j];
    end
    w_any   = |w_trip;
    w_first = '0;
    for (int k = int'(NSRC) - 1; k >= 0; k--) begin
      if (w_trip[k]) begin
        w_first = IDX_W'(k);
      end
    end
  end

  // Per-channel persistence counters, saturating.
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(N_AXIS); i++) begin
      if (reset || clear || !axis_block_sigs[i]) begin
        r_cnt[i] <= '0;
      end else if (r_cnt[i] != '1) begin
        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_MONITOR;
      r_block <= 1'b0;
      r_info  <= '0;
      r_first <= '0;
      r_stall <= '0;
      r_trips <= '0;
    end else if (clear) begin
      r_state <= S_MONITOR;
      r_block <= 1'b0;
      r_info  <= '0;
      r_stall <= '0;
      r_trips <= '0;
    end else begin
      case (r_state)
        S_MONITOR: begin
          if (w_any) begin
            r_state <= S_BLOCKED;
            r_block <= 1'b1;
            r_first <= w_first;
            r_stall <= CNT_W'(1);
            r_info  <= w_code;
            if (r_trips != 8'hFF) begin
              r_trips <= r_trips + 8'd1;
            end
          end
        end
        S_BLOCKED: begin
          if (w_any) begin
            if (r_stall != '1) begin
              r_stall <= r_stall + CNT_W'(1);
            end
            r_info <= (STICKY != 0) ? (r_info | w_code) : w_code;
          end else if (STICKY != 0) begin
            r_state <= S_LATCHED;
          end else begin
            r_state <= S_MONITOR;
            r_block <= 1'b0;
            r_info  <= '0;
          end
        end
        S_LATCHED: begin
          r_block <= 1'b1;
        end
        default: begin
          r_state <= S_MONITOR;
          r_block <= 1'b0;
          r_info  <= '0;
        end
      endcase
    end
  end

  assign axis_block_info = r_info;
  assign block           = r_block;
  assign first_idx       = r_first;
  assign stall_cycles    = r_stall;
  assign trip_count      = r_trips;

endmodule

// File: tb/tb_axis_stall_watchdog.sv
// Scoreboard bench: a live-report instance (CNT_W=16) and a sticky instance (CNT_W=4)
// share stimulus; a per-cycle reference model queues expected outputs for a monitor.
module tb_axis_stall_watchdog;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] thr;
  logic        clear;
  logic [1:0]  ab;
  logic [0:0]  ii;
  logic [0:0]  ib;

  logic [3:0]  info0, info1;
  logic        blk0, blk1;
  logic [1:0]  fi0, fi1;
  logic [15:0] sc0;
  logic [3:0]  sc1;
  logic [7:0]  tc0, tc1;

  always #5 clock = ~clock;

  axis_stall_watchdog #(.N_AXIS(2), .N_INST(1), .CNT_W(16), .STICKY(0)) dut0 (
    .clock(clock), .reset(reset), .threshold(thr), .clear(clear),
    .axis_block_sigs(ab), .inst_idle_sigs(ii), .inst_block_sigs(ib),
    .axis_block_info(info0), .block(blk0), .first_idx(fi0),
    .stall_cycles(sc0), .trip_count(tc0));

  axis_stall_watchdog #(.N_AXIS(2), .N_INST(1), .CNT_W(4), .STICKY(1)) dut1 (
    .clock(clock), .reset(reset), .threshold(thr[3:0]), .clear(clear),
    .axis_block_sigs(ab), .inst_idle_sigs(ii), .inst_block_sigs(ib),
    .axis_block_info(info1), .block(blk1), .first_idx(fi1),
    .stall_cycles(sc1), .trip_count(tc1));

  typedef struct {
    int blk;
    int info;
    int fi;
    int sc;
    int tc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: run = consecutive cycles a flag has been high (capped at counter max)
  int m_run   [2][2];
  int m_blk   [2];
  int m_lat   [2];
  int m_info  [2];
  int m_first [2];
  int m_sc    [2];
  int m_tc    [2];

  task automatic model(input int d, input int a, input int b, input int idl,
                       input int th, input int c, input int r);
    int cmax, te, any, first, codes;
    int trip[3];
    cmax = (d == 0) ? 65535 : 15;
    te   = (d == 0) ? th : (th % 16);
    if (te == 0) te = 1;
    any = 0; first = -1; codes = 0;
    for (int i = 0; i < 2; i++) begin
      trip[i] = (((a >> i) & 1) == 1) && (m_run[d][i] + 1 >= te);
      if (trip[i] != 0) codes += ((i % 2 == 0) ? 2 : 1) * (1 << (2 * i));
    end
    trip[2] = (b == 1) && (idl == 0);
    for (int k = 0; k < 3; k++) begin
      if (trip[k] != 0) begin
        any = 1;
        if (first < 0) first = k;
      end
    end
    if (r != 0) begin
      m_run[d][0] = 0; m_run[d][1] = 0;
      m_blk[d] = 0; m_lat[d] = 0; m_info[d] = 0; m_first[d] = 0; m_sc[d] = 0; m_tc[d] = 0;
    end else if (c != 0) begin
      m_run[d][0] = 0; m_run[d][1] = 0;
      m_blk[d] = 0; m_lat[d] = 0; m_info[d] = 0; m_sc[d] = 0; m_tc[d] = 0;
    end else begin
      for (int i = 0; i < 2; i++)
        m_run[d][i] = (((a >> i) & 1) == 1) ? ((m_run[d][i] < cmax) ? m_run[d][i] + 1 : cmax) : 0;
      if (m_blk[d] == 0) begin
        if (any != 0) begin
          m_blk[d] = 1; m_first[d] = first; m_sc[d] = 1; m_info[d] = codes;
          if (m_tc[d] < 255) m_tc[d]++;
        end
      end else if (m_lat[d] == 0) begin
        if (any != 0) begin
          if (m_sc[d] < cmax) m_sc[d]++;
          m_info[d] = (d == 1) ? (m_info[d] | codes) : codes;
        end else if (d == 1) begin
          m_lat[d] = 1;
        end else begin
          m_blk[d] = 0; m_info[d] = 0;
        end
      end
    end
  endtask

  task automatic step(input int a, input int b, input int idl, input int th,
                      input int c, input int r);
    exp_t e;
    @(negedge clock);
    ab = 2'(a); ib = 1'(b); ii = 1'(idl); thr = 16'(th); clear = 1'(c); reset = 1'(r);
    for (int d = 0; d < 2; d++) begin
      model(d, a, b, idl, th, c, r);
      e.blk = m_blk[d]; e.info = m_info[d]; e.fi = m_first[d]; e.sc = m_sc[d]; e.tc = m_tc[d];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, d, $time, act, exp);
    end
  endtask

  // Monitor: every edge the DUTs present a fresh report, compared against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("block", 0, int'(blk0), e.blk);
        chk("info", 0, int'(info0), e.info);
        chk("first_idx", 0, int'(fi0), e.fi);
        chk("stall_cycles", 0, int'(sc0), e.sc);
        chk("trip_count", 0, int'(tc0), e.tc);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("block", 1, int'(blk1), e.blk);
        chk("info", 1, int'(info1), e.info);
        chk("first_idx", 1, int'(fi1), e.fi);
        chk("stall_cycles", 1, int'(sc1), e.sc);
        chk("trip_count", 1, int'(tc1), e.tc);
      end
    end
  end

  task automatic rep(input int n, input int a, input int b, input int idl, input int th);
    for (int i = 0; i < n; i++) step(a, b, idl, th, 0, 0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; thr = '0; ab = '0; ii = '0; ib = '0;
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    // single channel, threshold 1
    rep(3, 1, 0, 0, 1);
    rep(2, 0, 0, 0, 1);
    // threshold 5, short burst must not trip
    rep(4, 2, 0, 0, 5);
    rep(1, 0, 0, 0, 5);
    rep(5, 2, 0, 0, 5);
    rep(2, 0, 0, 0, 5);
    step(0, 0, 0, 5, 1, 0);
    // simultaneous trips, then clear
    rep(6, 3, 0, 0, 3);
    rep(3, 0, 0, 0, 3);
    step(0, 0, 0, 3, 1, 0);
    rep(2, 0, 0, 0, 3);
    // instance source, busy then idle
    rep(2, 0, 1, 0, 3);
    rep(2, 0, 0, 0, 3);
    rep(3, 0, 1, 1, 3);
    step(0, 0, 0, 3, 1, 0);
    // trip_count saturation
    for (int i = 0; i < 260; i++) begin
      step(1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
    end
    rep(3, 1, 0, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    rep(2, 0, 0, 0, 1);
    // threshold 0 acts as 1
    rep(2, 1, 0, 0, 0);
    rep(2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    // long stall saturates the narrow counters
    rep(40, 1, 0, 0, 2);
    rep(2, 0, 0, 0, 2);
    step(0, 0, 0, 2, 1, 0);
    // clear while a trip is pending
    rep(2, 1, 0, 0, 3);
    step(1, 0, 0, 3, 1, 0);
    rep(4, 1, 0, 0, 3);
    rep(2, 0, 0, 0, 3);
    step(0, 0, 0, 3, 1, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
           int'($urandom_range(0, 39) == 0), int'($urandom_range(0, 249) == 0));
    end
    rep(3, 0, 0, 0, 1);
    @(negedge clock);
    @(negedge clock);
    chk("queue_drained", 0, q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
